// File: rtl/rca_acc32.sv
// Burst accumulator built around a 32-bit ripple-carry adder, with a valid/ready result port.
// Optional carry-out counter is enabled by defining RCA_ACC_CARRY_CNT_EN.

module rca32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);
  logic [32:0] w_c;

  assign w_c[0] = ci;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_fa
      assign s[gi]     = a[gi] ^ b[gi] ^ w_c[gi];
      assign w_c[gi+1] = (a[gi] & b[gi]) | (w_c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign co = w_c[32];
endmodule

module rca_acc32 #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic             out_ovf,
  output logic [7:0]       out_carry_cnt,
  output logic             busy
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_acc;
  logic [LEN_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic [31:0]      w_sum;
  logic             w_co;
  logic             w_accept;
  logic             w_start_idle;

  rca32 u_rca32 (
    .a  (r_acc),
    .b  (in_data),
    .ci (1'b0),
    .s  (w_sum),
    .co (w_co)
  );

  // r_in_ready is high exactly while in ACC, so it doubles as the state qualifier
  assign w_accept     = r_in_ready & in_valid;
  assign w_start_idle = (r_state == S_IDLE) & start;

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (len == {LEN_W{1'b0}}) ? S_DONE : S_ACC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACC: begin
        if (w_accept && (r_cnt == LEN_W'(1))) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_ACC;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register and handshake/status outputs registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == S_ACC);
      r_out_valid <= (w_state_nxt == S_DONE);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  // Accumulator, remaining-operand counter and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= 32'd0;
      r_cnt <= {LEN_W{1'b0}};
      r_ovf <= 1'b0;
    end else if (w_start_idle) begin
      r_acc <= 32'd0;
      r_cnt <= len;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_sum;
      r_cnt <= r_cnt - LEN_W'(1);
      r_ovf <= r_ovf | w_co;
    end else begin
      r_acc <= r_acc;
      r_cnt <= r_cnt;
      r_ovf <= r_ovf;
    end
  end

`ifdef RCA_ACC_CARRY_CNT_EN
  logic [7:0] r_carry_cnt;

  // Saturating carry-out counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_carry_cnt <= 8'd0;
    end else if (w_start_idle) begin
      r_carry_cnt <= 8'd0;
    end else if (w_accept && w_co && (r_carry_cnt != 8'd255)) begin
      r_carry_cnt <= r_carry_cnt + 8'd1;
    end else begin
      r_carry_cnt <= r_carry_cnt;
    end
  end

  assign out_carry_cnt = r_carry_cnt;
`else
  assign out_carry_cnt = 8'd0;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out_sum   = r_acc;
  assign out_ovf   = r_ovf;
endmodule

// File: tb/tb_rca_acc32.sv
// Directed scoreboard bench for rca_acc32: burst results are queued as driven and checked on out_valid.
module tb_rca_acc32;
  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_ovf;
  logic [7:0]  out_carry_cnt;
  logic        busy;

  typedef struct packed {
    logic [31:0] sum;
    logic        ovf;
    logic [7:0]  ccnt;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_acc;
  logic        m_ovf;
  logic [7:0]  m_ccnt;

  rca_acc32 #(.LEN_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .len           (len),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sum       (out_sum),
    .out_ovf       (out_ovf),
    .out_carry_cnt (out_carry_cnt),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_burst(input logic [7:0] l);
    m_acc  = 32'd0;
    m_ovf  = 1'b0;
    m_ccnt = 8'd0;
    start  = 1'b1;
    len    = l;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic feed(input logic [31:0] d, input int gap);
    logic [32:0] full;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    check("in_ready_acc", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    full = {1'b0, m_acc} + {1'b0, d};
    m_acc = full[31:0];
    if (full[32]) begin
      m_ovf = 1'b1;
      if (m_ccnt != 8'd255) m_ccnt = m_ccnt + 8'd1;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic push_expected();
    exp_t e;
    e.sum  = m_acc;
    e.ovf  = m_ovf;
`ifdef RCA_ACC_CARRY_CNT_EN
    e.ccnt = m_ccnt;
`else
    e.ccnt = 8'd0;
`endif
    sb_q.push_back(e);
  endtask

  task automatic take_result(input int hold, input logic start_in_hold);
    exp_t e;
    int   n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_seen", {31'd0, out_valid}, 32'd1);
    check("sb_nonempty", (sb_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("out_sum", out_sum, e.sum);
      check("out_ovf", {31'd0, out_ovf}, {31'd0, e.ovf});
      check("out_carry_cnt", {24'd0, out_carry_cnt}, {24'd0, e.ccnt});
      check("busy_done", {31'd0, busy}, 32'd1);
      check("in_ready_done", {31'd0, in_ready}, 32'd0);
      for (int h = 0; h < hold; h++) begin
        start = start_in_hold && (h == 1);
        @(negedge clk);
        start = 1'b0;
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_sum", out_sum, e.sum);
        check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
    end
    out_ready = 1'b1;
    start     = start_in_hold;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    check("valid_fall", {31'd0, out_valid}, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0;
    in_data = 32'd0; out_ready = 1'b0;
    m_acc = 32'd0; m_ovf = 1'b0; m_ccnt = 8'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sum", out_sum, 32'd0);
    check("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    check("rst_carry_cnt", {24'd0, out_carry_cnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // 1 + 2 + 3, back to back; valid must be up right after the last accept edge
    start_burst(8'd3);
    feed(32'd1, 0); feed(32'd2, 0); feed(32'd3, 0);
    push_expected();
    check("lat_valid", {31'd0, out_valid}, 32'd1);
    take_result(0, 1'b0);

    // wraparound with a carry-out
    start_burst(8'd2);
    feed(32'hFFFF_FFFF, 0); feed(32'h0000_0002, 0);
    push_expected();
    take_result(0, 1'b0);

    // gaps on input, stall on output, start ignored in DONE and on the handshake cycle
    start_burst(8'd3);
    feed(32'h1234_5678, 2); feed(32'h0F0F_0F0F, 2); feed(32'hA000_0001, 2);
    push_expected();
    take_result(5, 1'b1);

    // empty burst
    start_burst(8'd0);
    push_expected();
    check("len0_valid", {31'd0, out_valid}, 32'd1);
    take_result(0, 1'b0);

    // reset mid-burst discards the partial sum
    start_burst(8'd4);
    feed(32'd7, 0); feed(32'd9, 0);
    reset = 1'b1;
    #1;
    check("mid_rst_sum", out_sum, 32'd0);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ovf", {31'd0, out_ovf}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start_burst(8'd1);
    feed(32'h5, 0);
    push_expected();
    take_result(0, 1'b0);

    // maximum length, every operand all-ones
    start_burst(8'd255);
    for (int i = 0; i < 255; i++) feed(32'hFFFF_FFFF, 0);
    push_expected();
    check("max_model_sum", m_acc, 32'hFFFF_FF01);
    check("max_model_ccnt", {24'd0, m_ccnt}, 32'd254);
    take_result(1, 1'b0);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
